// File: rtl/disp_pkg.sv
// Shared display-select constants and the anode decode used by the digit demux.
package disp_pkg;

    localparam logic       DISP1     = 1'b1;
    localparam logic       DISP2     = 1'b0;
    localparam logic [1:0] ANODE_OFF = 2'b11;

    // Active-low decode clears the enabled display's bit out of ANODE_OFF.
    // Active-high output is the bitwise inverse of that.
    function automatic logic [1:0] anode_decode(input logic sel, input logic active_low);
        logic [1:0] low_enables;
        low_enables = (sel == DISP1) ? (ANODE_OFF & 2'b10) : (ANODE_OFF & 2'b01);
        return active_low ? low_enables : ~low_enables;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Free-running scan divider: scan_sel toggles each time the counter wraps.
module scan_divider
    import disp_pkg::*;
#(
    parameter int DIV_WIDTH = 18
) (
    input  logic clk,
    input  logic reset,
    output logic scan_sel
);

    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic                 scan_sel_reg;
    logic                 scan_sel_next;

    always_comb begin
        cnt_next      = cnt_reg + 1'b1;
        scan_sel_next = (&cnt_reg) ? ~scan_sel_reg : scan_sel_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg      <= '0;
            scan_sel_reg <= DISP1;
        end else begin
            cnt_reg      <= cnt_next;
            scan_sel_reg <= scan_sel_next;
        end
    end

    assign scan_sel = scan_sel_reg;

endmodule

// File: rtl/demux_2_1.sv
// Two-digit anode-select demux: picks the external or scanned select and
// decodes it into the two common-anode enables.
module demux_2_1
    import disp_pkg::*;
#(
    parameter int DIV_WIDTH  = 18,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_mode,
    input  logic       select_in,
    output logic       select_out,
    output logic [1:0] anode_out
);

    logic scan_sel;
    logic sel;

    // The divider runs regardless of ext_mode so switching back is seamless.
    scan_divider #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_scan_divider (
        .clk      (clk),
        .reset    (reset),
        .scan_sel (scan_sel)
    );

    assign sel        = ext_mode ? select_in : scan_sel;
    assign select_out = sel;
    assign anode_out  = anode_decode(sel, ACTIVE_LOW != 0);

endmodule

// File: tb/tb_demux_2_1.sv
// Randomized check of demux_2_1 against a cycles-since-reset model, plus literal pins.
module tb_demux_2_1;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_mode;
    logic       select_in;
    logic       select_out;
    logic [1:0] anode_out;
    logic       select_out_hi;
    logic [1:0] anode_out_hi;

    int tests  = 0;
    int failed = 0;

    int n     = 0;
    bit valid = 1'b0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    demux_2_1 #(.DIV_WIDTH(2), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .ext_mode   (ext_mode),
        .select_in  (select_in),
        .select_out (select_out),
        .anode_out  (anode_out)
    );

    demux_2_1 #(.DIV_WIDTH(2), .ACTIVE_LOW(0)) dut_hi (
        .clk        (clk),
        .reset      (reset),
        .ext_mode   (ext_mode),
        .select_in  (select_in),
        .select_out (select_out_hi),
        .anode_out  (anode_out_hi)
    );

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: n counts edges since the last reset edge; select holds for 4 edges per phase.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            n     <= 0;
            valid <= 1'b1;
        end else if (valid) begin
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        logic       exp_sel;
        logic [1:0] exp_lo;
        if (check_en && (ext_mode || valid)) begin
            exp_sel = ext_mode ? select_in : (((n / 4) % 2) == 0);
            exp_lo  = exp_sel ? 2'b10 : 2'b01;
            check("cyc_select_out", {1'b0, select_out}, {1'b0, exp_sel});
            check("cyc_anode_lo", anode_out, exp_lo);
            check("cyc_anode_hi", anode_out_hi, ~exp_lo);
            check("cyc_select_out_hi", {1'b0, select_out_hi}, {1'b0, exp_sel});
        end
    end

    initial begin
        logic [1:0] exp_seq [9];
        logic [1:0] exp_after [4];
        exp_seq   = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        exp_after = '{2'b10, 2'b10, 2'b10, 2'b01};

        reset     = 1'b0;
        ext_mode  = 1'b1;
        select_in = 1'b1;
        #1;
        check("ext_during_reset", anode_out, 2'b10);
        step();
        step();
        reset    = 1'b1;
        check_en = 1'b1;
        #1;
        check("ext_sel1_anode", anode_out, 2'b10);
        check("ext_sel1_select", {1'b0, select_out}, 2'b01);
        step();
        select_in = 1'b0;
        #1;
        check("ext_sel0_anode", anode_out, 2'b01);
        check("ext_sel0_select", {1'b0, select_out}, 2'b00);
        check("hi_sel0_anode", anode_out_hi, 2'b10);

        for (int i = 0; i < 4; i++) begin
            step();
            select_in = (i % 2 == 0);
            #1;
            check("ext_toggle", anode_out, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("hi_toggle", anode_out_hi, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Internal mode: reset held two edges, then released.
        ext_mode = 1'b0;
        reset    = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("int_reset_phase", anode_out, 2'b10);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("int_seq_%0d", k + 1), anode_out, exp_seq[k]);
        end

        // Mid-phase reset while display 2 is on.
        repeat (4) step();
        check("int_mid_before", anode_out, 2'b01);
        reset = 1'b0;
        step();
        check("int_mid_reset", anode_out, 2'b10);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("int_after_%0d", k + 1), anode_out, exp_after[k]);
        end

        for (int i = 0; i < 400; i++) begin
            step();
            ext_mode  = 1'($urandom_range(0, 1));
            select_in = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 19) != 0);
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        #1;
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
